// File: rtl/sram_stream_reader.sv
// Burst reader: streams LEN consecutive SRAM words (9-bit wrapping address) out over a valid/ready port.
// Optional macro SRAM_READER_OUT_REG_EN registers DOUT through a 2-entry skid buffer.
module sram_stream_reader (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [8:0]  BASE_ADDR,
    input  logic [9:0]  LEN,
    output logic        EN_M,
    output logic [8:0]  ADDR,
    input  logic [15:0] SRAM_DOUT,
    output logic [15:0] DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [8:0]  r_addr;
    logic [9:0]  r_issue_left;
    logic [9:0]  r_beat_left;
    logic        r_busy;
    logic        r_done;

    logic [9:0]  w_len_clamped;
    logic        w_start_ok;
    logic        w_xfer;
    logic        w_room;
    logic        w_en_m;

    assign w_len_clamped = (LEN > 10'd512) ? 10'd512 : LEN;
    assign w_start_ok    = START && (r_state == ST_IDLE) && !r_busy;
    assign w_xfer        = DOUT_VALID && DOUT_READY;

    // A read may only be issued when its word is guaranteed a slot; a stalled beat blocks it.
    assign w_en_m = (r_state == ST_READ) && (!DOUT_VALID || DOUT_READY) && w_room;

    assign EN_M = w_en_m;
    assign ADDR = r_addr;
    assign BUSY = r_busy;
    assign DONE = r_done;

    // Burst control: start, address issue, beat counting and completion.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_addr       <= 9'd0;
            r_issue_left <= 10'd0;
            r_beat_left  <= 10'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (w_start_ok) begin
                        if (w_len_clamped == 10'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state      <= ST_READ;
                            r_addr       <= BASE_ADDR;
                            r_issue_left <= w_len_clamped;
                            r_beat_left  <= w_len_clamped;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (w_en_m) begin
                        r_addr       <= r_addr + 9'd1;
                        r_issue_left <= r_issue_left - 10'd1;
                        if (r_issue_left == 10'd1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if ((r_state != ST_IDLE) && w_xfer) begin
                r_beat_left <= r_beat_left - 10'd1;
                if (r_beat_left == 10'd1) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

`ifdef SRAM_READER_OUT_REG_EN
    logic [1:0]  r_cnt;
    logic        r_rd_vld;
    logic [15:0] r_buf0;
    logic [15:0] r_buf1;
    logic [2:0]  w_occ_after;

    // Entries held after this edge; the word issued now lands one edge later.
    assign w_occ_after = {1'b0, r_cnt} + {2'b00, r_rd_vld} - {2'b00, w_xfer};
    assign w_room      = (w_occ_after <= 3'd1);
    assign DOUT_VALID  = (r_cnt != 2'd0);
    assign DOUT        = r_buf0;

    // Skid buffer: r_buf0 is the head presented on DOUT, r_buf1 the overflow slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt    <= 2'd0;
            r_rd_vld <= 1'b0;
            r_buf0   <= 16'h0000;
            r_buf1   <= 16'h0000;
        end else begin
            r_rd_vld <= w_en_m;
            case ({r_rd_vld, w_xfer})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_buf0 <= SRAM_DOUT;
                    end else begin
                        r_buf1 <= SRAM_DOUT;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_buf0 <= SRAM_DOUT;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= SRAM_DOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic r_valid;

    assign w_room     = 1'b1;
    assign DOUT_VALID = r_valid;
    assign DOUT       = r_valid ? SRAM_DOUT : 16'h0000;

    // The SRAM holds its word while EN_M=0, so only the valid flag needs registering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= 1'b0;
        end else if (w_en_m) begin
            r_valid <= 1'b1;
        end else if (DOUT_READY) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: SRAM model, table of bursts, reset corner cases, random bursts.
module tb_sram_stream_reader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [8:0]  BASE_ADDR;
    logic [9:0]  LEN;
    logic        EN_M;
    logic [8:0]  ADDR;
    logic [15:0] SRAM_DOUT;
    logic [15:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;
    logic        BUSY;
    logic        DONE;

`ifdef SRAM_READER_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic [15:0] mem [0:511];
    logic [8:0]  sram_q = 9'd0;
    int n_cmp  = 0;
    int n_fail = 0;

    sram_stream_reader dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
        .EN_M(EN_M), .ADDR(ADDR), .SRAM_DOUT(SRAM_DOUT), .DOUT(DOUT),
        .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // SRAM: captures address on EN_M, data held until the next capture.
    always @(posedge CLK) begin
        if (EN_M) sram_q <= ADDR;
    end
    assign SRAM_DOUT = mem[sram_q];

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  len;
        int          mode;   // 0 ready, 1 random ready, 2 stall beat 2, 3 START mid-burst
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_burst(input logic [8:0] base, input logic [9:0] len, input int mode,
                             output int nb, output logic [15:0] first, output logic [15:0] last);
        logic [15:0] q [$];
        int n, issued, beats, last_cyc, stalls, first_vld_cyc;
        bit prev_stall, seen_done;
        logic [15:0] prev_dout;
        n = (len > 10'd512) ? 512 : int'(len);
        for (int i = 0; i < n; i++) q.push_back(mem[(int'(base) + i) % 512]);
        issued = 0; beats = 0; last_cyc = -1; stalls = 0; first_vld_cyc = -1;
        prev_stall = 1'b0; seen_done = 1'b0; prev_dout = 16'h0; first = 16'h0; last = 16'h0;
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = base; LEN = len; DOUT_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0; BASE_ADDR = 9'($urandom); LEN = 10'($urandom);
        for (int cyc = 1; cyc <= 4000 && !seen_done; cyc++) begin
            if (cyc > 1) @(negedge CLK);
            case (mode)
                1: DOUT_READY = ($urandom_range(0, 3) != 0);
                2: begin
                    if (DOUT_VALID && beats == 2 && stalls < 3) begin
                        DOUT_READY = 1'b0;
                        stalls++;
                    end else begin
                        DOUT_READY = 1'b1;
                    end
                end
                default: DOUT_READY = 1'b1;
            endcase
            START = (mode == 3 && cyc == 3);
            if (START) begin
                BASE_ADDR = 9'h155;
                LEN = 10'd3;
            end
            #1;
            if (prev_stall) begin
                check("stall_valid", DOUT_VALID, 1);
                check("stall_dout", DOUT, prev_dout);
            end
            if (DOUT_VALID && first_vld_cyc < 0) begin
                first_vld_cyc = cyc;
                check("first_latency", cyc, LAT);
            end
            if (DOUT_VALID && !DOUT_READY) check("en_m_stall", EN_M, 0);
            if (EN_M) begin
                if (issued < n) check("addr", ADDR, (int'(base) + issued) % 512);
                issued++;
            end
            if (DOUT_VALID && DOUT_READY) begin
                if (beats < n) begin
                    check("beat_data", DOUT, q[beats]);
                    if (beats == 0) first = DOUT;
                    last = DOUT;
                end
                beats++;
                if (beats == n) last_cyc = cyc;
            end
            if (n == 0) begin
                check("len0_en_m", EN_M, 0);
                check("len0_valid", DOUT_VALID, 0);
            end
            if (DONE) begin
                seen_done = 1'b1;
                check("done_timing", cyc, (n == 0) ? 1 : last_cyc + 1);
                if (n > 0) check("busy_at_done", BUSY, 1);
            end else if (n > 0) begin
                check("busy_in_burst", BUSY, 1);
            end
            prev_stall = DOUT_VALID && !DOUT_READY;
            prev_dout  = DOUT;
        end
        START = 1'b0;
        check("done_seen", seen_done, 1);
        check("read_count", issued, n);
        check("beat_count", beats, n);
        if (mode == 2 && n > 2) check("stall_cycles", stalls, 3);
        @(negedge CLK);
        DOUT_READY = 1'b1;
        #1;
        check("busy_after", BUSY, 0);
        check("done_after", DONE, 0);
        check("valid_after", DOUT_VALID, 0);
        nb = beats;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb, xf;
        logic [15:0] f, l;
        for (int i = 0; i < 512; i++) mem[i] = 16'h9FF0 + 16'(i);
        tbl[0] = '{9'h010, 10'd4,   0, 4,   16'hA000, 16'hA003};
        tbl[1] = '{9'h010, 10'd4,   2, 4,   16'hA000, 16'hA003};
        tbl[2] = '{9'h1FE, 10'd4,   0, 4,   16'hA1EE, 16'h9FF1};
        tbl[3] = '{9'h0AB, 10'd0,   0, 0,   16'h0000, 16'h0000};
        tbl[4] = '{9'h000, 10'h3FF, 1, 512, 16'h9FF0, 16'hA1EF};
        tbl[5] = '{9'h005, 10'd512, 0, 512, 16'h9FF5, 16'h9FF4};
        tbl[6] = '{9'h100, 10'd513, 1, 512, 16'hA0F0, 16'hA0EF};
        tbl[7] = '{9'h1FF, 10'd1,   2, 1,   16'hA1EF, 16'hA1EF};
        tbl[8] = '{9'h040, 10'd6,   3, 6,   16'hA030, 16'hA035};

        RESET = 1'b1; START = 1'b0; BASE_ADDR = 9'h1AA; LEN = 10'd7; DOUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_en_m", EN_M, 0);
        check("rst_addr", ADDR, 0);
        check("rst_valid", DOUT_VALID, 0);
        check("rst_dout", DOUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        RESET = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_burst(tbl[i].base, tbl[i].len, tbl[i].mode, nb, f, l);
            check("tbl_beats", nb, tbl[i].exp_n);
            check("tbl_first", f, tbl[i].exp_first);
            check("tbl_last", l, tbl[i].exp_last);
        end

        // Reset in the middle of a LEN=8 burst after two beats.
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 9'h020; LEN = 10'd8; DOUT_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        xf = 0;
        for (int c = 0; c < 20 && xf < 2; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (DOUT_VALID && DOUT_READY) xf++;
        end
        check("rst_beats_seen", xf, 2);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("abort_en_m", EN_M, 0);
        check("abort_addr", ADDR, 0);
        check("abort_valid", DOUT_VALID, 0);
        check("abort_dout", DOUT, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            #1;
            check("abort_quiet", {DONE, BUSY, EN_M, DOUT_VALID}, 4'b0000);
        end

        // Reset wins over a simultaneous START.
        @(negedge CLK);
        RESET = 1'b1; START = 1'b1; BASE_ADDR = 9'h077; LEN = 10'd5;
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0;
        #1;
        check("rst_start_busy", BUSY, 0);
        check("rst_start_en_m", EN_M, 0);
        @(negedge CLK);
        #1;
        check("rst_start_idle", {BUSY, EN_M, DONE}, 3'b000);

        run_burst(9'h030, 10'd5, 0, nb, f, l);
        check("post_rst_beats", nb, 5);
        check("post_rst_first", f, 16'hA020);
        check("post_rst_last", l, 16'hA024);

        for (int r = 0; r < 10; r++) begin
            logic [9:0] rl;
            rl = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
            run_burst(9'($urandom), rl, 1, nb, f, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
